// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch unit, load/store unit, arbiter and the unified memory port.
// The arbiter takes the slave view; requesters and the memory model take the master view.
interface mem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  if_req_i;
    logic [ADDR_WIDTH-1:0] if_addr_i;
    logic                  if_gnt_o;
    logic                  if_rvalid_o;
    logic [DATA_WIDTH-1:0] if_rdata_o;

    logic                  d_req_i;
    logic                  d_we_i;
    logic [ADDR_WIDTH-1:0] d_addr_i;
    logic [DATA_WIDTH-1:0] d_wdata_i;
    logic                  d_gnt_o;
    logic                  d_rvalid_o;
    logic [DATA_WIDTH-1:0] d_rdata_o;

    logic                  mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    logic                  busy_o;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
        output d_gnt_o, d_rvalid_o, d_rdata_o,
        output mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i,
        output busy_o
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        output d_req_i, d_we_i, d_addr_i, d_wdata_i,
        input  d_gnt_o, d_rvalid_o, d_rdata_o,
        input  mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i,
        input  busy_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction at a time,
// with data-port priority bounded by a fetch starvation limit.
module mem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_READ, S_RESP} state_t;

    state_t                r_state;
    logic                  r_owner_if;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_we;
    logic [CNT_W-1:0]      r_starve;
    logic                  r_mem_we;
    logic                  r_busy;
    logic                  r_if_rvalid;
    logic                  r_d_rvalid;
    logic [DATA_WIDTH-1:0] r_if_rdata;
    logic [DATA_WIDTH-1:0] r_d_rdata;

    logic w_idle;
    logic w_if_win;
    logic w_if_gnt;
    logic w_d_gnt;

    // Grants are combinational in IDLE; gating with rst_n keeps them low while reset is held.
    assign w_idle   = (r_state == S_IDLE) && rst_n;
    assign w_if_win = bus.if_req_i && (!bus.d_req_i || (r_starve == LIM));
    assign w_if_gnt = w_idle && w_if_win;
    assign w_d_gnt  = w_idle && bus.d_req_i && !w_if_win;

    assign bus.if_gnt_o    = w_if_gnt;
    assign bus.d_gnt_o     = w_d_gnt;
    assign bus.if_rvalid_o = r_if_rvalid;
    assign bus.d_rvalid_o  = r_d_rvalid;
    assign bus.if_rdata_o  = r_if_rdata;
    assign bus.d_rdata_o   = r_d_rdata;
    assign bus.mem_we_o    = r_mem_we;
    assign bus.mem_addr_o  = r_addr;
    assign bus.mem_wdata_o = r_wdata;
    assign bus.busy_o      = r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_owner_if  <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_we        <= 1'b0;
            r_starve    <= '0;
            r_mem_we    <= 1'b0;
            r_busy      <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_mem_we    <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!bus.if_req_i)
                        r_starve <= '0;
                    else if (w_d_gnt && (r_starve != LIM))
                        r_starve <= r_starve + CNT_W'(1);
                    else if (w_if_gnt)
                        r_starve <= '0;

                    if (w_if_gnt) begin
                        r_owner_if <= 1'b1;
                        r_addr     <= bus.if_addr_i;
                        r_wdata    <= '0;
                        r_we       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_ACCESS;
                    end else if (w_d_gnt) begin
                        r_owner_if <= 1'b0;
                        r_addr     <= bus.d_addr_i;
                        r_wdata    <= bus.d_wdata_i;
                        r_we       <= bus.d_we_i;
                        r_mem_we   <= bus.d_we_i;
                        r_busy     <= 1'b1;
                        r_state    <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // The ROM registers the address on this edge; writes complete here.
                    if (r_we) begin
                        r_d_rvalid <= 1'b1;
                        r_state    <= S_RESP;
                    end else begin
                        r_state    <= S_READ;
                    end
                end
                S_READ: begin
                    if (r_owner_if) begin
                        r_if_rdata  <= bus.mem_rdata_i;
                        r_if_rvalid <= 1'b1;
                    end else begin
                        r_d_rdata   <= bus.mem_rdata_i;
                        r_d_rvalid  <= 1'b1;
                    end
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: drivers queue expected responses, a monitor checks them
// against what the arbiter presents on each port and on the memory side.
module tb_mem_arbiter;
    localparam int DW = 32;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

    mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Memory model: fixed ROM/RAM contents plus anything written, one-cycle registered read.
    logic [31:0] wr_m [logic [31:0]];
    logic [31:0] r_mem_rd = '0;

    function automatic logic [31:0] mem_peek(input logic [31:0] a);
        if (wr_m.exists(a)) return wr_m[a];
        case (a)
            32'h0040_0000: return 32'h2002_0005;
            32'h0040_0004: return 32'h8C88_0004;
            32'h1001_0004: return 32'h1234_5678;
            default:       return a ^ 32'hA5A5_0000;
        endcase
    endfunction

    always @(posedge clk) begin
        r_mem_rd <= mem_peek(bus.mem_addr_o);
        if (bus.mem_we_o) wr_m[bus.mem_addr_o] = bus.mem_wdata_o;
    end
    assign bus.mem_rdata_i = r_mem_rd;

    typedef struct { logic [31:0] data; int lat; } rsp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;

    rsp_t exp_if_q[$];
    rsp_t exp_d_q[$];
    wr_t  exp_wr_q[$];
    bit   exp_gnt_q[$];   // 1 = fetch, 0 = data

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int g_if_cyc = 0;
    int g_d_cyc = 0;
    logic [31:0] g_addr = '0;
    logic [31:0] last_d_rd = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got an unexpected pulse, expected none", name);
    endtask

    function automatic logic [159:0] outs();
        return {bus.if_gnt_o, bus.if_rvalid_o, bus.if_rdata_o,
                bus.d_gnt_o, bus.d_rvalid_o, bus.d_rdata_o,
                bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.busy_o};
    endfunction

    // Monitor
    always @(negedge clk) begin : mon
        rsp_t r;
        wr_t  w;
        if (bus.if_gnt_o || bus.d_gnt_o) begin
            chk("gnt_excl_and_idle", {bus.if_gnt_o & bus.d_gnt_o, bus.busy_o}, 0);
            if (exp_gnt_q.size() == 0) unexpected("gnt_order");
            else chk("gnt_order", bus.if_gnt_o, exp_gnt_q.pop_front());
            if (bus.if_gnt_o) begin
                g_if_cyc = cyc;
                g_addr   = bus.if_addr_i;
            end else begin
                g_d_cyc  = cyc;
                g_addr   = bus.d_addr_i;
            end
        end
        if (bus.busy_o) chk("mem_addr_hold", bus.mem_addr_o, g_addr);
        if (bus.mem_we_o) begin
            if (exp_wr_q.size() == 0) unexpected("mem_we");
            else begin
                w = exp_wr_q.pop_front();
                chk("mem_wr_addr", bus.mem_addr_o, w.addr);
                chk("mem_wr_data", bus.mem_wdata_o, w.data);
                chk("mem_we_cycle", cyc - g_d_cyc, 1);
            end
        end
        if (bus.if_rvalid_o || bus.d_rvalid_o)
            chk("rvalid_excl", bus.if_rvalid_o & bus.d_rvalid_o, 0);
        if (bus.if_rvalid_o) begin
            if (exp_if_q.size() == 0) unexpected("if_rvalid");
            else begin
                r = exp_if_q.pop_front();
                chk("if_rdata", bus.if_rdata_o, r.data);
                chk("if_latency", cyc - g_if_cyc, r.lat);
            end
        end
        if (bus.d_rvalid_o) begin
            if (exp_d_q.size() == 0) unexpected("d_rvalid");
            else begin
                r = exp_d_q.pop_front();
                chk("d_rdata", bus.d_rdata_o, r.data);
                chk("d_latency", cyc - g_d_cyc, r.lat);
            end
        end
    end

    task automatic if_access(input logic [31:0] addr, input logic [31:0] rd);
        bit got = 1'b0;
        exp_if_q.push_back('{rd, 3});
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = addr;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            got = bus.if_gnt_o;
        end
        if (!got) begin
            n_cmp++; n_fail++;
            $display("FAIL if_gnt_timeout: got no grant, expected one within 60 cycles");
        end
        @(posedge clk); #1;
        bus.if_req_i  = 1'b0;
        bus.if_addr_i = '0;
    endtask

    task automatic d_access(input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rd);
        bit got = 1'b0;
        if (we) begin
            exp_d_q.push_back('{last_d_rd, 2});
            exp_wr_q.push_back('{addr, wdata});
        end else begin
            exp_d_q.push_back('{rd, 3});
            last_d_rd = rd;
        end
        bus.d_req_i   = 1'b1;
        bus.d_we_i    = we;
        bus.d_addr_i  = addr;
        bus.d_wdata_i = wdata;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            got = bus.d_gnt_o;
        end
        if (!got) begin
            n_cmp++; n_fail++;
            $display("FAIL d_gnt_timeout: got no grant, expected one within 60 cycles");
        end
        @(posedge clk); #1;
        bus.d_req_i   = 1'b0;
        bus.d_we_i    = 1'b0;
        bus.d_addr_i  = '0;
        bus.d_wdata_i = '0;
    endtask

    task automatic settle();
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic flush_expect();
        exp_if_q.delete();
        exp_d_q.delete();
        exp_wr_q.delete();
        exp_gnt_q.delete();
        last_d_rd = '0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got no end of test, expected finish before 20000 time units");
        $fatal(1);
    end

    initial begin
        bit got;
        bus.if_req_i = 1'b0; bus.if_addr_i = '0;
        bus.d_req_i = 1'b0; bus.d_we_i = 1'b0; bus.d_addr_i = '0; bus.d_wdata_i = '0;

        repeat (2) @(posedge clk);
        #1 chk("reset_outputs", outs(), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("busy_after_init", bus.busy_o, 0);

        // Fetch read
        exp_gnt_q.push_back(1'b1);
        if_access(32'h0040_0000, 32'h2002_0005);
        settle();

        // Data write, then read it back
        exp_gnt_q.push_back(1'b0);
        d_access(1'b1, 32'h1001_0000, 32'hDEAD_BEEF, '0);
        settle();
        exp_gnt_q.push_back(1'b0);
        d_access(1'b0, 32'h1001_0000, '0, 32'hDEAD_BEEF);
        settle();

        // Simultaneous requests: data first, fetch right after data RESP
        exp_gnt_q.push_back(1'b0);
        exp_gnt_q.push_back(1'b1);
        fork
            d_access(1'b0, 32'h1001_0004, '0, 32'h1234_5678);
            if_access(32'h0040_0004, 32'h8C88_0004);
        join
        settle();
        chk("fetch_after_data", g_if_cyc - g_d_cyc, 4);

        // Starvation: D, D, I repeated
        for (int i = 0; i < 3; i++) begin
            exp_gnt_q.push_back(1'b0);
            exp_gnt_q.push_back(1'b0);
            exp_gnt_q.push_back(1'b1);
        end
        fork
            begin
                for (int i = 0; i < 6; i++) d_access(1'b0, 32'h1001_0004, '0, 32'h1234_5678);
            end
            begin
                for (int i = 0; i < 3; i++) if_access(32'h0040_0000, 32'h2002_0005);
            end
        join
        settle();

        // Reset in the middle of a fetch read
        exp_gnt_q.push_back(1'b1);
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h0040_0004;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = bus.if_gnt_o;
        end
        chk("rst_fetch_gnt", got, 1);
        @(posedge clk); #1;
        bus.if_req_i = 1'b0; bus.if_addr_i = '0;
        #1 rst_n = 1'b0;
        #1 chk("reset_midrun", outs(), 0);
        flush_expect();
        @(negedge clk) rst_n = 1'b1;
        #1 chk("busy_after_reset", bus.busy_o, 0);
        repeat (6) @(posedge clk);
        #1;

        // Reset during the ACCESS cycle of a write
        exp_gnt_q.push_back(1'b0);
        bus.d_req_i = 1'b1; bus.d_we_i = 1'b1;
        bus.d_addr_i = 32'h1001_0008; bus.d_wdata_i = 32'h0000_55AA;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = bus.d_gnt_o;
        end
        chk("rst_write_gnt", got, 1);
        @(posedge clk); #1;
        bus.d_req_i = 1'b0; bus.d_we_i = 1'b0; bus.d_addr_i = '0; bus.d_wdata_i = '0;
        chk("we_in_access", {bus.mem_we_o, bus.busy_o}, 2'b11);
        #1 rst_n = 1'b0;
        #1 chk("we_async_drop", {bus.mem_we_o, bus.d_rvalid_o, bus.busy_o}, 0);
        flush_expect();
        @(negedge clk) rst_n = 1'b1;
        #1 chk("busy_after_wr_reset", bus.busy_o, 0);
        repeat (6) @(posedge clk);
        #1;

        // Normal service after reset
        exp_gnt_q.push_back(1'b0);
        d_access(1'b1, 32'h1001_000C, 32'hCAFE_F00D, '0);
        settle();
        exp_gnt_q.push_back(1'b0);
        d_access(1'b0, 32'h1001_000C, '0, 32'hCAFE_F00D);
        settle();
        exp_gnt_q.push_back(1'b1);
        if_access(32'h0040_0004, 32'h8C88_0004);
        settle();

        chk("pending_expectations",
            {exp_if_q.size(), exp_d_q.size(), exp_wr_q.size(), exp_gnt_q.size()}, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
